// File: rtl/regfile_loader_pkg.sv
// Shared types and sizes for the register-file preload initiator.
package regfile_loader_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    VERIFY  = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_loader_byte_packer.sv
// Assembles four accepted bytes into one 32-bit word. The word and its
// valid pulse are combinational on the 4th byte so the loader can latch the
// word on the same edge that accepts that byte.
module regfile_loader_byte_packer
  import regfile_loader_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_vld_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        lane;

  // Merge the incoming byte into its lane and compute the next partial word.
  always_comb begin
    lane       = LITTLE_ENDIAN ? cnt_q : (2'd3 - cnt_q);
    word_o     = word_q;
    case (lane)
      2'd0: word_o[7:0]   = byte_i;
      2'd1: word_o[15:8]  = byte_i;
      2'd2: word_o[23:16] = byte_i;
      2'd3: word_o[31:24] = byte_i;
    endcase
    word_vld_o = byte_vld_i && (cnt_q == 2'd3);
    cnt_d      = cnt_q;
    word_d     = word_q;
    if (clear_i) begin
      cnt_d  = 2'd0;
      word_d = '0;
    end else if (byte_vld_i) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = word_vld_o ? '0 : word_o;
    end
  end

  // Byte counter and partial word; a reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/regfile_loader.sv
// Register-file preloader: streams bytes in, packs them into words, writes a
// contiguous register range and optionally reads each one back to compare.
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter bit VERIFY_EN     = 1'b1,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] first_reg,
  input  logic [5:0]            num_regs,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [REG_ADDR_W-1:0] rf_writereg,
  output logic [DATA_W-1:0]     rf_writedata,
  output logic                  rf_RegWrite,
  output logic                  rf_regDist,
  output logic [REG_ADDR_W-1:0] rf_readreg1,
  output logic                  rf_regRead,
  input  logic [DATA_W-1:0]     rf_readdata1,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [REG_ADDR_W-1:0] err_reg,
  output logic [5:0]            loaded_count
);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] cur_reg_q, cur_reg_d;
  logic [5:0]            remaining_q, remaining_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  error_q, error_d;
  logic [REG_ADDR_W-1:0] err_reg_q, err_reg_d;
  logic [5:0]            count_q, count_d;

  logic                  start_ok;
  logic                  advance;
  logic                  pk_clear;
  logic [DATA_W-1:0]     pk_word;
  logic                  pk_word_vld;

  // The range check is done in 7 bits so first_reg+num_regs cannot wrap.
  assign start_ok = (num_regs != 6'd0) &&
                    (({2'b00, first_reg} + {1'b0, num_regs}) <= 7'(REG_COUNT));

  regfile_loader_byte_packer #(
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (pk_clear),
    .byte_vld_i(s_valid && (state_q == COLLECT)),
    .byte_i    (s_data),
    .word_o    (pk_word),
    .word_vld_o(pk_word_vld)
  );

  // Next-state, bookkeeping and strobe decode for the load sequence.
  always_comb begin
    state_d     = state_q;
    cur_reg_d   = cur_reg_q;
    remaining_d = remaining_q;
    wdata_d     = wdata_q;
    error_d     = error_q;
    err_reg_d   = err_reg_q;
    count_d     = count_q;
    pk_clear    = 1'b0;
    advance     = 1'b0;
    s_ready     = 1'b0;
    rf_RegWrite = 1'b0;
    rf_regRead  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d     = COLLECT;
            cur_reg_d   = first_reg;
            remaining_d = num_regs;
            error_d     = 1'b0;
            err_reg_d   = '0;
            count_d     = 6'd0;
            pk_clear    = 1'b1;
          end else begin
            error_d   = 1'b1;
            err_reg_d = first_reg;
          end
        end
      end
      COLLECT: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (pk_word_vld) begin
          wdata_d = pk_word;
          count_d = count_q + 6'd1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy        = 1'b1;
        // Register 0 is hardwired; its word is consumed but not written.
        rf_RegWrite = (cur_reg_q != '0);
        if (VERIFY_EN && (cur_reg_q != '0)) state_d = VERIFY;
        else                                advance = 1'b1;
      end
      VERIFY: begin
        busy       = 1'b1;
        rf_regRead = 1'b1;
        if ((rf_readdata1 != wdata_q) && !error_q) begin
          error_d   = 1'b1;
          err_reg_d = cur_reg_q;
        end
        advance = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (advance) begin
      remaining_d = remaining_q - 6'd1;
      if (remaining_q == 6'd1) begin
        state_d = DONE;
      end else begin
        cur_reg_d = cur_reg_q + 5'd1;
        state_d   = COLLECT;
      end
    end
  end

  // State and datapath registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_reg_q   <= '0;
      remaining_q <= 6'd0;
      wdata_q     <= '0;
      error_q     <= 1'b0;
      err_reg_q   <= '0;
      count_q     <= 6'd0;
    end else begin
      state_q     <= state_d;
      cur_reg_q   <= cur_reg_d;
      remaining_q <= remaining_d;
      wdata_q     <= wdata_d;
      error_q     <= error_d;
      err_reg_q   <= err_reg_d;
      count_q     <= count_d;
    end
  end

  assign rf_writereg  = cur_reg_q;
  assign rf_writedata = wdata_q;
  assign rf_readreg1  = cur_reg_q;
  assign rf_regDist   = 1'b1;
  assign error        = error_q;
  assign err_reg      = err_reg_q;
  assign loaded_count = count_q;

endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader: a LE/verify instance driven through directed
// sequences and a table of randomized loads, plus a BE/no-verify instance.
module tb_regfile_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start, s_valid, s_ready, rf_RegWrite, rf_regDist, rf_regRead, busy, done, error;
  logic [4:0]  first_reg, rf_writereg, rf_readreg1, err_reg;
  logic [5:0]  num_regs, loaded_count;
  logic [7:0]  s_data;
  logic [31:0] rf_writedata, rf_readdata1;

  logic        b_start, b_s_valid, b_s_ready, b_rf_RegWrite, b_rf_regDist, b_rf_regRead, b_busy, b_done, b_error;
  logic [4:0]  b_first_reg, b_rf_writereg, b_rf_readreg1, b_err_reg;
  logic [5:0]  b_num_regs, b_loaded_count;
  logic [7:0]  b_s_data;
  logic [31:0] b_rf_writedata, b_rf_readdata1;

  regfile_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .num_regs(num_regs),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rf_writereg(rf_writereg), .rf_writedata(rf_writedata), .rf_RegWrite(rf_RegWrite),
    .rf_regDist(rf_regDist), .rf_readreg1(rf_readreg1), .rf_regRead(rf_regRead),
    .rf_readdata1(rf_readdata1), .busy(busy), .done(done), .error(error),
    .err_reg(err_reg), .loaded_count(loaded_count)
  );

  regfile_loader #(.VERIFY_EN(1'b0), .LITTLE_ENDIAN(1'b0)) u_dut_be (
    .clk(clk), .rst_n(rst_n), .start(b_start), .first_reg(b_first_reg), .num_regs(b_num_regs),
    .s_valid(b_s_valid), .s_data(b_s_data), .s_ready(b_s_ready),
    .rf_writereg(b_rf_writereg), .rf_writedata(b_rf_writedata), .rf_RegWrite(b_rf_RegWrite),
    .rf_regDist(b_rf_regDist), .rf_readreg1(b_rf_readreg1), .rf_regRead(b_rf_regRead),
    .rf_readdata1(b_rf_readdata1), .busy(b_busy), .done(b_done), .error(b_error),
    .err_reg(b_err_reg), .loaded_count(b_loaded_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Register file models behind both instances.
  logic [31:0] rfa [32];
  logic [31:0] rfb [32];
  logic [31:0] exp_rf [32];
  bit          clr_rf = 1'b1;
  int          wr_a = 0, wr0_a = 0, wr_b = 0;
  logic [31:0] kill_mask = '0;

  always @(posedge clk) begin
    if (clr_rf) begin
      for (int i = 0; i < 32; i++) begin
        rfa[i] <= '0;
        rfb[i] <= '0;
      end
    end else begin
      if (rf_RegWrite) begin
        rfa[rf_writereg] <= rf_writedata;
        wr_a <= wr_a + 1;
        if (rf_writereg == 5'd0) wr0_a <= wr0_a + 1;
      end
      if (b_rf_RegWrite) begin
        rfb[b_rf_writereg] <= b_rf_writedata;
        wr_b <= wr_b + 1;
      end
    end
  end

  assign rf_readdata1   = kill_mask[rf_readreg1] ? 32'h0 : rfa[rf_readreg1];
  assign b_rf_readdata1 = rfb[b_rf_readreg1];

  // Port-level invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n && !clr_rf) begin
      chk("rw_exclusive", 32'(rf_RegWrite & rf_regRead), 32'd0);
      chk("write_only_when_busy", 32'(rf_RegWrite & ~busy), 32'd0);
      chk("regDist_high", 32'(rf_regDist), 32'd1);
      chk("be_never_reads", 32'(b_rf_regRead), 32'd0);
    end
  end

  // Reference model: stream bytes, word assembly, expected register image, latency.
  logic [7:0] byte_q [$];
  int         exp_lc = 0;

  function automatic logic [31:0] word_of(int k, bit le);
    logic [7:0] c0, c1, c2, c3;
    c0 = byte_q[4*k]; c1 = byte_q[4*k+1]; c2 = byte_q[4*k+2]; c3 = byte_q[4*k+3];
    return le ? {c3, c2, c1, c0} : {c0, c1, c2, c3};
  endfunction

  task automatic apply_exp(input int f, input int nw, input bit le);
    for (int k = 0; k < nw; k++)
      if ((f + k) != 0) exp_rf[f+k] = word_of(k, le);
  endtask

  function automatic int exp_cycles(int f, int n, bit ver);
    int c = 1;
    for (int k = 0; k < n; k++) c += 5 + ((ver && (f + k) != 0) ? 1 : 0);
    return c;
  endfunction

  task automatic check_rf(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), rfa[i], exp_rf[i]);
  endtask

  // Drives one load on the LE instance with optional stall or reset abort.
  task automatic run_a(input logic [4:0] f, input logic [5:0] n, input int stall_at, input int stall_len,
                       input int abort_at, input int max_cyc,
                       output int done_cyc, output bit busy1, output bit err1, output bit aborted);
    int idx = 0;
    int cyc = 0;
    int stalled = 0;
    done_cyc = -1; busy1 = 1'b0; err1 = 1'b1; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; first_reg = f; num_regs = n; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc <= max_cyc) begin
      if (cyc == 1) begin busy1 = busy; err1 = error; end
      if (done) begin done_cyc = cyc; break; end
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0; s_valid = 1'b0; #1; aborted = 1'b1; break;
      end
      start     = (cyc == 3);
      first_reg = (cyc == 3) ? ~f : f;
      if (stalled < stall_len && idx == stall_at) begin
        s_valid = 1'b0; stalled++;
        chk("stall_hold_ready", 32'(s_ready), 32'd1);
      end else begin
        s_valid = (idx < byte_q.size());
        s_data  = s_valid ? byte_q[idx] : 8'h00;
      end
      if (s_valid && s_ready) idx++;
      @(negedge clk); cyc++;
    end
    start = 1'b0; s_valid = 1'b0; first_reg = f;
    if (done_cyc > 0) begin
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic check_load(input string tag, input int f, input int n, input int dc, input int want_dc,
                            input int wb, input bit b1, input bit e1, input bit want_err, input logic [4:0] want_er);
    chk({tag, "_done_cyc"}, dc, want_dc);
    chk({tag, "_busy_on_start"}, 32'(b1), 32'd1);
    chk({tag, "_error_cleared"}, 32'(e1), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'(want_err));
    if (want_err) chk({tag, "_err_reg"}, err_reg, want_er);
    chk({tag, "_loaded_count"}, loaded_count, exp_lc);
    chk({tag, "_writes"}, wr_a - wb, n - ((f == 0) ? 1 : 0));
    chk({tag, "_r0_writes"}, wr0_a, 0);
    check_rf(tag);
  endtask

  task automatic reject_a(input string tag, input logic [4:0] f, input logic [5:0] n);
    int  wb  = wr_a;
    bit  bsy = 1'b0;
    @(negedge clk);
    start = 1'b1; first_reg = f; num_regs = n;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bsy |= busy;
      @(negedge clk);
    end
    chk({tag, "_rej_error"}, 32'(error), 32'd1);
    chk({tag, "_rej_err_reg"}, err_reg, f);
    chk({tag, "_rej_busy"}, 32'(bsy), 32'd0);
    chk({tag, "_rej_writes"}, wr_a - wb, 0);
    chk({tag, "_rej_loaded"}, loaded_count, exp_lc);
  endtask

  typedef struct {
    logic [4:0] f;
    logic [5:0] n;
    bit         acc;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [12];
    int   dc, wb, cyc, idx;
    bit   b1, e1, ab;

    rst_n = 1'b0; start = 1'b0; first_reg = '0; num_regs = '0; s_valid = 1'b0; s_data = '0;
    b_start = 1'b0; b_first_reg = '0; b_num_regs = '0; b_s_valid = 1'b0; b_s_data = '0;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_s_ready", 32'(s_ready), 0);       chk("rst_RegWrite", 32'(rf_RegWrite), 0);
    chk("rst_regRead", 32'(rf_regRead), 0);    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);             chk("rst_error", 32'(error), 0);
    chk("rst_writereg", rf_writereg, 0);       chk("rst_writedata", rf_writedata, 0);
    chk("rst_readreg1", rf_readreg1, 0);       chk("rst_err_reg", err_reg, 0);
    chk("rst_loaded", loaded_count, 0);        chk("rst_regDist", 32'(rf_regDist), 1);
    chk("rst_be_busy", 32'(b_busy), 0);        chk("rst_be_regDist", 32'(b_rf_regDist), 1);
    clr_rf = 1'b0;
    rst_n  = 1'b1;

    // Two-register little-endian load with known words.
    byte_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wb = wr_a;
    run_a(5'd8, 6'd2, -1, 0, -1, 100, dc, b1, e1, ab);
    apply_exp(8, 2, 1'b1); exp_lc = 2;
    chk("t1_r8", rfa[8], 32'h12345678);
    chk("t1_r9", rfa[9], 32'hDEADBEEF);
    check_load("t1", 8, 2, dc, 13, wb, b1, e1, 1'b0, 5'd0);

    // Register 0 is consumed but never written.
    byte_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    wb = wr_a;
    run_a(5'd0, 6'd2, -1, 0, -1, 100, dc, b1, e1, ab);
    apply_exp(0, 2, 1'b1); exp_lc = 2;
    chk("t2_r1", rfa[1], 32'h00000005);
    chk("t2_r0", rfa[0], 32'h00000000);
    check_load("t2", 0, 2, dc, 12, wb, b1, e1, 1'b0, 5'd0);

    // Read-back mismatch on r3 and r5: first failing register is kept.
    byte_q.delete();
    for (int k = 0; k < 12; k++) byte_q.push_back(8'($urandom));
    byte_q[0] = 8'hA5; byte_q[8] = 8'h3C;
    kill_mask = 32'h0000_0028;
    wb = wr_a;
    run_a(5'd3, 6'd3, -1, 0, -1, 100, dc, b1, e1, ab);
    kill_mask = '0;
    apply_exp(3, 3, 1'b1); exp_lc = 3;
    check_load("t3", 3, 3, dc, 19, wb, b1, e1, 1'b1, 5'd3);

    // Backpressure: s_valid dropped for 10 cycles after byte 2.
    byte_q.delete();
    for (int k = 0; k < 4; k++) byte_q.push_back(8'($urandom));
    wb = wr_a;
    run_a(5'd10, 6'd1, 2, 10, -1, 100, dc, b1, e1, ab);
    apply_exp(10, 1, 1'b1); exp_lc = 1;
    check_load("t5", 10, 1, dc, exp_cycles(10, 1, 1'b1) + 10, wb, b1, e1, 1'b0, 5'd0);

    // Reset mid-load after byte 2 of the second word.
    byte_q.delete();
    for (int k = 0; k < 8; k++) byte_q.push_back(8'($urandom));
    wb = wr_a;
    run_a(5'd12, 6'd2, -1, 0, 6, 100, dc, b1, e1, ab);
    chk("abort_reached", 32'(ab), 32'd1);
    chk("abort_s_ready", 32'(s_ready), 0);    chk("abort_RegWrite", 32'(rf_RegWrite), 0);
    chk("abort_regRead", 32'(rf_regRead), 0); chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);          chk("abort_error", 32'(error), 0);
    chk("abort_writereg", rf_writereg, 0);    chk("abort_writedata", rf_writedata, 0);
    chk("abort_readreg1", rf_readreg1, 0);    chk("abort_err_reg", err_reg, 0);
    chk("abort_loaded", loaded_count, 0);     chk("abort_regDist", 32'(rf_regDist), 1);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done_after", 32'(done), 0);
    apply_exp(12, 1, 1'b1); exp_lc = 0;
    chk("abort_writes", wr_a - wb, 1);
    check_rf("abort");

    // Table of randomized loads and range rejects.
    vt[0]  = '{5'd31, 6'd1,  1'b1};
    vt[1]  = '{5'd0,  6'd32, 1'b1};
    vt[2]  = '{5'd17, 6'd16, 1'b0};
    vt[3]  = '{5'd16, 6'd16, 1'b1};
    vt[4]  = '{5'd5,  6'd0,  1'b0};
    vt[5]  = '{5'd20, 6'd5,  1'b1};
    vt[6]  = '{5'd30, 6'd3,  1'b0};
    vt[7]  = '{5'd1,  6'd31, 1'b1};
    vt[8]  = '{5'd2,  6'd40, 1'b0};
    vt[9]  = '{5'd0,  6'd1,  1'b1};
    vt[10] = '{5'd7,  6'd9,  1'b1};
    vt[11] = '{5'd30, 6'd2,  1'b1};
    for (int v = 0; v < 12; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      if (vt[v].acc) begin
        byte_q.delete();
        for (int k = 0; k < 4 * int'(vt[v].n); k++) byte_q.push_back(8'($urandom));
        wb = wr_a;
        run_a(vt[v].f, vt[v].n, -1, 0, -1, 400, dc, b1, e1, ab);
        apply_exp(vt[v].f, vt[v].n, 1'b1); exp_lc = vt[v].n;
        check_load(tag, vt[v].f, vt[v].n, dc, exp_cycles(vt[v].f, vt[v].n, 1'b1), wb, b1, e1, 1'b0, 5'd0);
      end else begin
        reject_a(tag, vt[v].f, vt[v].n);
      end
    end

    // Big-endian instance without read-back: one word into r31.
    byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    @(negedge clk);
    b_start = 1'b1; b_first_reg = 5'd31; b_num_regs = 6'd1;
    @(negedge clk);
    b_start = 1'b0; cyc = 1; idx = 0; dc = -1;
    while (cyc <= 50) begin
      if (b_done) begin dc = cyc; break; end
      b_s_valid = (idx < 4);
      b_s_data  = b_s_valid ? byte_q[idx] : 8'h00;
      if (b_s_valid && b_s_ready) idx++;
      @(negedge clk); cyc++;
    end
    b_s_valid = 1'b0;
    chk("be_done_cyc", dc, exp_cycles(31, 1, 1'b0));
    chk("be_r31", rfb[31], 32'h12345678);
    chk("be_r31_model", rfb[31], word_of(0, 1'b0));
    chk("be_error", 32'(b_error), 0);
    chk("be_loaded", b_loaded_count, 1);
    chk("be_writes", wr_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_loader.md
Name: regfile_loader

Overview:
- Write-side initiator for the 32x32 register file.
- Accepts a byte stream over valid/ready, assembles 32-bit words, and writes them to a contiguous register range through the register file write port.
- Optionally reads each register back through read port 1 and flags mismatches.
- Sits beside the datapath; used at boot and in test to preload registers before instruction fetch is released.

Parameters:
- VERIFY_EN, 1: 1 = read back and compare every written register; 0 = skip the VERIFY state.
- LITTLE_ENDIAN, 1: 1 = first byte received is bits [7:0]; 0 = first byte is bits [31:24].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- first_reg  in  5  first destination register; sampled at an accepted start.
- num_regs  in  6  register count, 1..32; sampled at an accepted start.
- s_valid  in  1  byte available.
- s_data  in  8  byte payload.
- s_ready  out  1  loader accepts a byte this cycle.
- rf_writereg  out  5  register file write address.
- rf_writedata  out  32  register file write data.
- rf_RegWrite  out  1  register file write enable.
- rf_regDist  out  1  write-destination select; held at 1.
- rf_readreg1  out  5  register file read address 1.
- rf_regRead  out  1  register file read enable.
- rf_readdata1  in  32  register file read data 1.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag; cleared by the next accepted start.
- err_reg  out  5  index of the first failing register.
- loaded_count  out  6  number of words consumed in the current or last load.

Behaviour:
- Reset (async, rst_n=0): state IDLE. s_ready, rf_RegWrite, rf_regRead, busy, done and error are 0. rf_writereg, rf_writedata, rf_readreg1, err_reg and loaded_count are 0. rf_regDist is 1.
- States: IDLE, COLLECT, WRITE, VERIFY, DONE.
- IDLE:
  - start=1 with valid parameters: latch cur_reg=first_reg and remaining=num_regs, clear error/err_reg/loaded_count, go to COLLECT.
  - start=1 with num_regs==0 or first_reg+num_regs>32: reject the start, set error=1, err_reg=first_reg, stay in IDLE, busy stays 0.
- COLLECT:
  - s_ready=1; a byte transfers when s_valid&&s_ready.
  - 2-bit byte counter places each byte per LITTLE_ENDIAN.
  - On the 4th transfer: assembled word goes to rf_writedata, loaded_count increments, go to WRITE. No wait on that same cycle.
- WRITE (one cycle):
  - s_ready=0; rf_writereg=cur_reg; rf_RegWrite=1 unless cur_reg==0.
  - Register 0 word is consumed and counted but never written.
  - Next state is VERIFY if VERIFY_EN and cur_reg!=0; otherwise the advance step below.
- VERIFY (one cycle):
  - rf_readreg1=cur_reg, rf_regRead=1, rf_RegWrite=0.
  - rf_readdata1 is sampled at the closing edge and compared with the latched word.
  - Mismatch: if error was 0, set error=1 and err_reg=cur_reg. Loading continues either way.
- Advance step: remaining decrements, cur_reg increments. If remaining becomes 0, go to DONE; else go to COLLECT.
- DONE: done=1 for one cycle, busy falls, go to IDLE.
- rf_RegWrite is never asserted outside WRITE; rf_regRead is never asserted outside VERIFY.
- Throughput per register with s_valid held high: 4 COLLECT + 1 WRITE + 1 VERIFY = 6 cycles (5 with VERIFY_EN=0).
- Total latency, start to done: 1 + 6*num_regs cycles.
- s_valid low stalls COLLECT indefinitely; the partial word is kept.
- start while busy is ignored.
- rst_n asserted mid-load aborts immediately. A partial word is discarded, registers already written stay written, and no done pulse is produced.
- Arithmetic: cur_reg is 5-bit. The range check guarantees no wrap past 31.

Decomposition:
- Shared package holds:
  - state enum (IDLE, COLLECT, WRITE, VERIFY, DONE);
  - REG_COUNT=32, REG_ADDR_W=5, DATA_W=32.
- One natural sub-module: byte_packer. It handles the 2-bit counter, endian placement, the word_valid pulse and the clear input.
- The FSM, counters and compare logic stay in regfile_loader.

Test Plan:
- Load 2 registers, first_reg=8, num_regs=2, LE, bytes 78 56 34 12 EF BE AD DE, s_valid always 1 -> r8=0x12345678, r9=0xDEADBEEF; done at cycle 13 after start; error=0; loaded_count=2.
- Register 0 skip: first_reg=0, num_regs=2, bytes 01 00 00 00 05 00 00 00 -> no RegWrite for r0, r0 stays 0, r1=5, loaded_count=2, error=0.
- Verify mismatch: force rf_readdata1=0 while verifying r3 in load first_reg=3, num_regs=3 -> error=1, err_reg=3, r4 and r5 still written, done pulses.
- Range reject: first_reg=30, num_regs=3 -> error=1, err_reg=30, busy never rises, no RegWrite.
- Backpressure and reset: drop s_valid for 10 cycles after byte 2 -> state holds, word correct when resumed; assert rst_n=0 after byte 2 of a second word -> outputs return to reset values, that register is unwritten, no done.
- BE with VERIFY_EN=0: bytes 12 34 56 78 to r31 -> r31=0x12345678; done 6 cycles after start.
